// File: rtl/spi_frame_decoder_pkg.sv
// Shared types and status-byte layout for the SPI frame decoder.
package spi_frame_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DISCARD
  } state_t;

  localparam logic [3:0] STATUS_TAG = 4'hA;
  localparam int unsigned STAT_FULL = 0;
  localparam int unsigned STAT_CHK  = 1;
  localparam int unsigned STAT_LEN  = 2;
  localparam int unsigned STAT_OVF  = 3;

  function automatic logic [7:0] make_status(input logic ovf, input logic len_err,
                                             input logic chk_err, input logic full);
    logic [7:0] s;
    s = {STATUS_TAG, 4'h0};
    s[STAT_OVF]  = ovf;
    s[STAT_LEN]  = len_err;
    s[STAT_CHK]  = chk_err;
    s[STAT_FULL] = full;
    return s;
  endfunction

  // States in which a CS rise means the frame was cut short.
  function automatic logic in_frame(input state_t s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous payload FIFO, 9-bit {last,data} entries, registered head output.
module spi_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Push,
  input  logic [8:0] i_Push_Data,
  input  logic       i_Pop,
  output logic [8:0] o_Rd_Data,
  output logic       o_Full,
  output logic       o_Empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic          push_ok, pop_ok;

  assign o_Full  = (count == DEPTH_C);
  assign o_Empty = (count == '0);

  always_comb begin
    pop_ok   = i_Pop & ~o_Empty;
    push_ok  = i_Push & (~o_Full | pop_ok);
    rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem[wr_ptr] <= i_Push_Data;
  end

  // Head register bypasses the write when the pushed entry becomes the new head.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_Rd_Data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (count_n == '0)
        o_Rd_Data <= '0;
      else if (push_ok && (wr_ptr == rd_ptr_n))
        o_Rd_Data <= i_Push_Data;
      else
        o_Rd_Data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses SPI slave bytes into CMD/LEN/payload/CHK frames, buffers payload and
// returns a status byte on every received byte.
module spi_frame_decoder
  import spi_frame_decoder_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CS_SYNC_STAGES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_SPI_CS_n,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [7:0] o_Cmd,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  input  logic       i_Data_Ready,
  output logic       o_Data_Last,
  output logic       o_Frame_Done,
  output logic       o_Err_Checksum,
  output logic       o_Err_Length,
  output logic       o_Err_Overflow,
  output logic       o_Err_Abort
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [CS_SYNC_STAGES-1:0] cs_sync;
  logic cs_s, cs_d, cs_fall, cs_rise;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, xor_q, xor_n, new_xor, cmd_n;
  logic       ovf_q, ovf_n, ovf_live, len_err_q, len_err_n, prev_chk_q, prev_chk_n;
  logic       push_q, push_n;
  logic [8:0] push_data_q, push_data_n;
  logic       tx_dv_n, cmd_valid_n, done_n;
  logic [7:0] tx_byte_n;
  logic       e_chk_n, e_len_n, e_ovf_n, e_abort_n;

  logic       fifo_full, fifo_empty, fifo_pop, drop;
  logic [8:0] fifo_rd;

  assign cs_s    = cs_sync[CS_SYNC_STAGES-1];
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;

  assign o_Data_Valid = ~fifo_empty;
  assign o_Data       = fifo_rd[7:0];
  assign o_Data_Last  = fifo_rd[8];
  assign fifo_pop     = o_Data_Valid & i_Data_Ready;
  // A push arriving on a full FIFO is lost unless a pop frees a slot that cycle.
  assign drop         = push_q & fifo_full & ~fifo_pop;
  assign ovf_live     = ovf_q | drop;

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Push      (push_q),
    .i_Push_Data (push_data_q),
    .i_Pop       (fifo_pop),
    .o_Rd_Data   (fifo_rd),
    .o_Full      (fifo_full),
    .o_Empty     (fifo_empty)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    xor_n       = xor_q;
    new_xor     = xor_q ^ i_RX_Byte;
    cmd_n       = o_Cmd;
    ovf_n       = ovf_live;
    len_err_n   = len_err_q;
    prev_chk_n  = prev_chk_q;
    push_n      = 1'b0;
    push_data_n = push_data_q;
    tx_dv_n     = 1'b0;
    tx_byte_n   = o_TX_Byte;
    cmd_valid_n = 1'b0;
    done_n      = 1'b0;
    e_chk_n     = 1'b0;
    e_len_n     = 1'b0;
    e_ovf_n     = 1'b0;
    e_abort_n   = 1'b0;

    if (cs_fall) begin
      state_n   = ST_CMD;
      xor_n     = '0;
      ovf_n     = 1'b0;
      len_err_n = 1'b0;
      tx_dv_n   = 1'b1;
    end else begin
      if (i_RX_DV && (state != ST_IDLE)) begin
        tx_dv_n = 1'b1;
        xor_n   = new_xor;
        case (state)
          ST_CMD: begin
            cmd_n       = i_RX_Byte;
            cmd_valid_n = 1'b1;
            state_n     = ST_LEN;
          end
          ST_LEN: begin
            if (i_RX_Byte > MAX_LEN_B) begin
              done_n     = 1'b1;
              e_len_n    = 1'b1;
              len_err_n  = 1'b1;
              prev_chk_n = 1'b0;
              state_n    = ST_DISCARD;
            end else if (i_RX_Byte == 8'd0) begin
              state_n = ST_CHK;
            end else begin
              cnt_n   = i_RX_Byte;
              state_n = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            push_n      = 1'b1;
            push_data_n = {cnt == 8'd1, i_RX_Byte};
            cnt_n       = cnt - 8'd1;
            if (cnt == 8'd1) state_n = ST_CHK;
          end
          ST_CHK: begin
            done_n     = 1'b1;
            e_chk_n    = (new_xor != 8'd0);
            e_ovf_n    = ovf_live;
            prev_chk_n = e_chk_n;
            state_n    = ST_DISCARD;
          end
          default: ;
        endcase
      end
      // Evaluated after the byte so a completing CHK wins over the abort.
      if (cs_rise) begin
        if (in_frame(state_n)) begin
          done_n     = 1'b1;
          e_abort_n  = 1'b1;
          e_ovf_n    = ovf_live;
          prev_chk_n = 1'b0;
        end
        state_n = ST_IDLE;
      end
    end

    if (tx_dv_n) tx_byte_n = make_status(ovf_n, len_err_n, prev_chk_n, fifo_full);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cs_sync        <= '1;
      cs_d           <= 1'b1;
      state          <= ST_IDLE;
      cnt            <= '0;
      xor_q          <= '0;
      ovf_q          <= 1'b0;
      len_err_q      <= 1'b0;
      prev_chk_q     <= 1'b0;
      push_q         <= 1'b0;
      push_data_q    <= '0;
      o_TX_DV        <= 1'b0;
      o_TX_Byte      <= '0;
      o_Cmd          <= '0;
      o_Cmd_Valid    <= 1'b0;
      o_Frame_Done   <= 1'b0;
      o_Err_Checksum <= 1'b0;
      o_Err_Length   <= 1'b0;
      o_Err_Overflow <= 1'b0;
      o_Err_Abort    <= 1'b0;
    end else begin
      cs_sync        <= {cs_sync[CS_SYNC_STAGES-2:0], i_SPI_CS_n};
      cs_d           <= cs_s;
      state          <= state_n;
      cnt            <= cnt_n;
      xor_q          <= xor_n;
      ovf_q          <= ovf_n;
      len_err_q      <= len_err_n;
      prev_chk_q     <= prev_chk_n;
      push_q         <= push_n;
      push_data_q    <= push_data_n;
      o_TX_DV        <= tx_dv_n;
      o_TX_Byte      <= tx_byte_n;
      o_Cmd          <= cmd_n;
      o_Cmd_Valid    <= cmd_valid_n;
      o_Frame_Done   <= done_n;
      o_Err_Checksum <= e_chk_n;
      o_Err_Length   <= e_len_n;
      o_Err_Overflow <= e_ovf_n;
      o_Err_Abort    <= e_abort_n;
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed, table-driven bench for spi_frame_decoder.
module tb_spi_frame_decoder;

  localparam int unsigned STAGES = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
  logic       i_SPI_CS_n = 1'b1;
  logic       i_Data_Ready = 1'b1;
  logic       o_TX_DV, o_Cmd_Valid, o_Data_Valid, o_Data_Last, o_Frame_Done;
  logic       o_Err_Checksum, o_Err_Length, o_Err_Overflow, o_Err_Abort;
  logic [7:0] o_TX_Byte, o_Cmd, o_Data;

  always #5 i_Clk = ~i_Clk;

  spi_frame_decoder #(.MAX_LEN(64), .FIFO_DEPTH(16), .CS_SYNC_STAGES(STAGES)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .i_SPI_CS_n(i_SPI_CS_n), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .o_Cmd(o_Cmd), .o_Cmd_Valid(o_Cmd_Valid), .o_Data(o_Data),
    .o_Data_Valid(o_Data_Valid), .i_Data_Ready(i_Data_Ready),
    .o_Data_Last(o_Data_Last), .o_Frame_Done(o_Frame_Done),
    .o_Err_Checksum(o_Err_Checksum), .o_Err_Length(o_Err_Length),
    .o_Err_Overflow(o_Err_Overflow), .o_Err_Abort(o_Err_Abort)
  );

  int errors = 0;
  int checks = 0;

  int         cv_cnt, fd_cnt;
  logic [7:0] cv_val;
  logic [3:0] fd_flags;
  logic [7:0] tx_q[$];
  logic [8:0] pop_q[$];

  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (o_Cmd_Valid) begin cv_cnt++; cv_val = o_Cmd; end
      if (o_Frame_Done) begin
        fd_cnt++;
        fd_flags = {o_Err_Checksum, o_Err_Length, o_Err_Overflow, o_Err_Abort};
      end
      if (o_TX_DV) tx_q.push_back(o_TX_Byte);
      if (o_Data_Valid && i_Data_Ready) pop_q.push_back({o_Data_Last, o_Data});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cv_cnt = 0; fd_cnt = 0; cv_val = '0; fd_flags = '0;
    tx_q.delete(); pop_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RX_Byte = b; i_RX_DV = 1'b1;
    tick(1);
    i_RX_DV = 1'b0;
    tick(3);
  endtask

  function automatic logic [32:0] all_outs();
    return {o_TX_DV, o_TX_Byte, o_Cmd, o_Cmd_Valid, o_Data, o_Data_Valid, o_Data_Last,
            o_Frame_Done, o_Err_Checksum, o_Err_Length, o_Err_Overflow, o_Err_Abort};
  endfunction

  // e_flags = {checksum, length, overflow, abort}; payload byte i = base + 0x11*i
  typedef struct {
    logic [7:0] cmd, len, base, chk;
    bit         auto_chk;
    int         n_pay;
    bit         send_chk;
    bit         ready;
    logic [3:0] e_flags;
    int         e_stored;
    logic [7:0] e_s0, e_sl;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] x, b;
    logic [8:0] exp_e;
    clear_mon();
    i_Data_Ready = v.ready;
    i_SPI_CS_n = 1'b0;
    tick(STAGES + 3);
    x = v.cmd ^ v.len;
    send_byte(v.cmd);
    send_byte(v.len);
    for (int i = 0; i < v.n_pay; i++) begin
      b = v.base + 8'(i * 17);
      x ^= b;
      send_byte(b);
    end
    if (v.send_chk) send_byte(v.auto_chk ? x : v.chk);
    tick(2);
    i_SPI_CS_n = 1'b1;
    tick(STAGES + 4);
    i_Data_Ready = 1'b1;
    tick(24);
    check($sformatf("v%0d_cmd_valid_cnt", idx), cv_cnt, 1);
    check($sformatf("v%0d_cmd", idx), cv_val, v.cmd);
    check($sformatf("v%0d_done_cnt", idx), fd_cnt, 1);
    check($sformatf("v%0d_err_flags", idx), fd_flags, v.e_flags);
    check($sformatf("v%0d_stored", idx), pop_q.size(), v.e_stored);
    for (int i = 0; i < v.e_stored && i < pop_q.size(); i++) begin
      exp_e = {(i == int'(v.len) - 1), v.base + 8'(i * 17)};
      check($sformatf("v%0d_data%0d", idx, i), pop_q[i], exp_e);
    end
    check($sformatf("v%0d_tx_cnt", idx), tx_q.size(), 3 + v.n_pay + int'(v.send_chk));
    if (tx_q.size() > 0) begin
      check($sformatf("v%0d_status_first", idx), tx_q[0], v.e_s0);
      check($sformatf("v%0d_status_last", idx), tx_q[tx_q.size()-1], v.e_sl);
    end
  endtask

  initial begin
    int n_tx;
    vecs[0] = '{cmd:8'h01, len:8'h03, base:8'hAA, chk:8'hDF, auto_chk:0, n_pay:3, send_chk:1,
                ready:1, e_flags:4'b0000, e_stored:3, e_s0:8'hA0, e_sl:8'hA0};
    vecs[1] = '{cmd:8'h01, len:8'h03, base:8'hAA, chk:8'h00, auto_chk:0, n_pay:3, send_chk:1,
                ready:1, e_flags:4'b1000, e_stored:3, e_s0:8'hA0, e_sl:8'hA2};
    vecs[2] = '{cmd:8'h02, len:8'h01, base:8'h55, chk:8'h00, auto_chk:1, n_pay:1, send_chk:1,
                ready:1, e_flags:4'b0000, e_stored:1, e_s0:8'hA2, e_sl:8'hA0};
    vecs[3] = '{cmd:8'h05, len:8'h00, base:8'h00, chk:8'h00, auto_chk:1, n_pay:0, send_chk:1,
                ready:1, e_flags:4'b0000, e_stored:0, e_s0:8'hA0, e_sl:8'hA0};
    vecs[4] = '{cmd:8'h07, len:8'h41, base:8'h11, chk:8'h00, auto_chk:0, n_pay:3, send_chk:0,
                ready:1, e_flags:4'b0100, e_stored:0, e_s0:8'hA0, e_sl:8'hA4};
    vecs[5] = '{cmd:8'h10, len:8'h14, base:8'h10, chk:8'h00, auto_chk:1, n_pay:20, send_chk:1,
                ready:0, e_flags:4'b0010, e_stored:16, e_s0:8'hA0, e_sl:8'hA9};
    vecs[6] = '{cmd:8'h20, len:8'h05, base:8'h01, chk:8'h00, auto_chk:0, n_pay:2, send_chk:0,
                ready:1, e_flags:4'b0001, e_stored:2, e_s0:8'hA0, e_sl:8'hA0};
    vecs[7] = '{cmd:8'h21, len:8'h02, base:8'h40, chk:8'h00, auto_chk:1, n_pay:2, send_chk:1,
                ready:1, e_flags:4'b0000, e_stored:2, e_s0:8'hA0, e_sl:8'hA0};

    clear_mon();
    tick(3);
    check("reset_outputs", all_outs(), '0);
    i_Rst = 1'b0;
    tick(STAGES + 2);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a payload, then a full frame.
    clear_mon();
    i_Data_Ready = 1'b0;
    i_SPI_CS_n = 1'b0;
    tick(STAGES + 3);
    send_byte(8'h30); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    tick(2);
    check("pre_reset_valid", o_Data_Valid, 1);
    i_SPI_CS_n = 1'b1;
    i_Rst = 1'b1;
    tick(2);
    check("midframe_reset_outputs", all_outs(), '0);
    i_Rst = 1'b0;
    tick(STAGES + 3);
    check("post_reset_empty", o_Data_Valid, 0);
    i_Data_Ready = 1'b1;
    run_vec(8, vecs[0]);

    // CHK byte lands in the same cycle the synchronised CS rises.
    clear_mon();
    i_SPI_CS_n = 1'b0;
    tick(STAGES + 3);
    send_byte(8'h33); send_byte(8'h01); send_byte(8'h44);
    i_SPI_CS_n = 1'b1;
    tick(STAGES);
    i_RX_Byte = 8'h76; i_RX_DV = 1'b1;
    tick(1);
    i_RX_DV = 1'b0;
    tick(6);
    check("edge_done_cnt", fd_cnt, 1);
    check("edge_err_flags", fd_flags, 4'b0000);
    check("edge_cmd", cv_val, 8'h33);
    check("edge_tx_cnt", tx_q.size(), 5);
    n_tx = tx_q.size();
    send_byte(8'h5A);
    tick(2);
    check("idle_no_tx", tx_q.size(), n_tx);
    check("idle_no_cmd", cv_cnt, 1);
    check("edge_stored", pop_q.size(), 1);
    if (pop_q.size() > 0) check("edge_data", pop_q[0], 9'h144);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
